vu_commit_collector: RTL and testbench

//  Scalar-unit side of the vector command protocol: the responder that closes each command_t loop.

---
 rtl/vu_commit_collector_if.sv | 30 +++
 rtl/vu_commit_collector.sv | 124 ++++++++++++
 tb/tb_vu_commit_collector.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vu_commit_collector_if.sv
// Command-issue and lane-commit bundle between the scalar issuer, the vector lanes and the commit collector.
// The master modport drives the issue and commit inputs; the slave modport is the collector itself.
interface vu_commit_collector_if #(
    parameter int NUM_LANE         = 4,
    parameter int NUM_ENTRY_HAZARD = 8
);
    localparam int W = $clog2(NUM_ENTRY_HAZARD);

    logic                    I_Issue;
    logic [W-1:0]            I_Issue_No;
    logic [NUM_LANE-1:0]     I_En_Lane;
    logic                    O_Full;
    logic                    O_Empty;
    logic [W:0]              O_Num_Pending;
    logic [NUM_LANE-1:0]     I_Lane_Commit;
    logic [NUM_LANE*W-1:0]   I_Lane_Issue_No;
    logic                    O_Commit;
    logic [W-1:0]            O_Commit_No;
    logic                    O_Err;

    modport master (
        output I_Issue, I_Issue_No, I_En_Lane, I_Lane_Commit, I_Lane_Issue_No,
        input  O_Full, O_Empty, O_Num_Pending, O_Commit, O_Commit_No, O_Err
    );

    modport slave (
        input  I_Issue, I_Issue_No, I_En_Lane, I_Lane_Commit, I_Lane_Issue_No,
        output O_Full, O_Empty, O_Num_Pending, O_Commit, O_Commit_No, O_Err
    );
endinterface

// File: rtl/vu_commit_collector.sv
// Tracks issued vector commands, gathers per-lane commits and retires commands strictly in issue order.
// Retire is one cycle after the head completes; O_Full holds off the issuer, O_Err flags protocol violations.
module vu_commit_collector #(
    parameter int NUM_LANE         = 4,
    parameter int NUM_ENTRY_HAZARD = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    vu_commit_collector_if.slave bus
);
    localparam int W = $clog2(NUM_ENTRY_HAZARD);
    localparam logic [W:0] C_DEPTH = (W+1)'(NUM_ENTRY_HAZARD);

    logic [NUM_ENTRY_HAZARD-1:0]                r_v;
    logic [NUM_ENTRY_HAZARD-1:0][NUM_LANE-1:0]  r_en_lane;
    logic [NUM_ENTRY_HAZARD-1:0][NUM_LANE-1:0]  r_en_commit;
    logic [NUM_ENTRY_HAZARD-1:0][W-1:0]         r_fifo;
    logic [W-1:0]                               r_head;
    logic [W-1:0]                               r_tail;
    logic [W:0]                                 r_count;
    logic                                       r_commit;
    logic [W-1:0]                               r_commit_no;
    logic                                       r_full;
    logic                                       r_empty;
    logic                                       r_err;

    logic [W-1:0]                               w_head_no;
    logic                                       w_retire;
    logic                                       w_issue_ok;
    logic                                       w_issue_err;
    logic [NUM_ENTRY_HAZARD-1:0]                w_v;
    logic [NUM_ENTRY_HAZARD-1:0][NUM_LANE-1:0]  w_en_lane;
    logic [NUM_ENTRY_HAZARD-1:0][NUM_LANE-1:0]  w_en_commit;
    logic [W-1:0]                               w_lane_no;
    logic                                       w_lane_err;
    logic [W:0]                                 w_count;

    assign w_head_no = r_fifo[r_head];
    assign w_retire  = (r_count != '0) && r_v[w_head_no] &&
                       (r_en_commit[w_head_no] == r_en_lane[w_head_no]);

    // A full table still accepts an issue when the head retires in the same cycle, and the
    // retiring issue_no may be reused immediately.
    assign w_issue_ok  = bus.I_Issue && (!r_full || w_retire) &&
                         !(r_v[bus.I_Issue_No] && !(w_retire && (w_head_no == bus.I_Issue_No)));
    assign w_issue_err = bus.I_Issue && !w_issue_ok;

    // Retire clears first, issue overwrites, then lane commits see the resulting entry.
    always_comb begin
        w_v         = r_v;
        w_en_lane   = r_en_lane;
        w_en_commit = r_en_commit;
        w_lane_no   = '0;
        w_lane_err  = 1'b0;
        if (w_retire) begin
            w_v[w_head_no] = 1'b0;
        end
        if (w_issue_ok) begin
            w_v[bus.I_Issue_No]         = 1'b1;
            w_en_lane[bus.I_Issue_No]   = bus.I_En_Lane;
            w_en_commit[bus.I_Issue_No] = '0;
        end
        for (int l = 0; l < NUM_LANE; l++) begin
            w_lane_no = bus.I_Lane_Issue_No[l*W +: W];
            if (bus.I_Lane_Commit[l]) begin
                if (w_v[w_lane_no] && w_en_lane[w_lane_no][l] && !w_en_commit[w_lane_no][l]) begin
                    w_en_commit[w_lane_no][l] = 1'b1;
                end else begin
                    w_lane_err = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_count = r_count;
        if (w_issue_ok && !w_retire) begin
            w_count = r_count + (W+1)'(1);
        end else if (!w_issue_ok && w_retire) begin
            w_count = r_count - (W+1)'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_v         <= '0;
            r_en_lane   <= '0;
            r_en_commit <= '0;
            r_fifo      <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_commit    <= 1'b0;
            r_commit_no <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_v         <= w_v;
            r_en_lane   <= w_en_lane;
            r_en_commit <= w_en_commit;
            if (w_issue_ok) begin
                r_fifo[r_tail] <= bus.I_Issue_No;
                r_tail         <= r_tail + W'(1);
            end
            if (w_retire) begin
                r_head      <= r_head + W'(1);
                r_commit_no <= w_head_no;
            end
            r_commit <= w_retire;
            r_count  <= w_count;
            r_full   <= (w_count == C_DEPTH);
            r_empty  <= (w_count == '0);
            r_err    <= r_err | w_issue_err | w_lane_err;
        end
    end

    assign bus.O_Full        = r_full;
    assign bus.O_Empty       = r_empty;
    assign bus.O_Num_Pending = r_count;
    assign bus.O_Commit      = r_commit;
    assign bus.O_Commit_No   = r_commit_no;
    assign bus.O_Err         = r_err;
endmodule

// File: tb/tb_vu_commit_collector.sv
// Directed bench for vu_commit_collector: a vector table for in-order retirement plus
// hand-written sequences for full table, issue/retire collision, errors and async reset.
module tb_vu_commit_collector;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    vu_commit_collector_if #(.NUM_LANE(4), .NUM_ENTRY_HAZARD(8)) bus ();

    vu_commit_collector #(.NUM_LANE(4), .NUM_ENTRY_HAZARD(8)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        issue;
        logic [2:0]  issue_no;
        logic [3:0]  en_lane;
        logic [3:0]  lc;
        logic [11:0] lno;
        logic        e_commit;
        logic [2:0]  e_no;
        logic        e_full;
        logic        e_empty;
        logic [3:0]  e_pend;
        logic        e_err;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(logic issue, logic [2:0] no, logic [3:0] mask, logic [3:0] lc,
                                logic [11:0] lno, logic ec, logic [2:0] eno, logic ef,
                                logic ee, logic [3:0] ep, logic er);
        vec_t v;
        v.issue = issue; v.issue_no = no; v.en_lane = mask; v.lc = lc; v.lno = lno;
        v.e_commit = ec; v.e_no = eno; v.e_full = ef; v.e_empty = ee; v.e_pend = ep; v.e_err = er;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(string tag, logic ec, logic [2:0] eno, logic ef, logic ee,
                              logic [3:0] ep, logic er);
        chk({tag, ".commit"}, int'(bus.O_Commit), int'(ec));
        if (ec) chk({tag, ".commit_no"}, int'(bus.O_Commit_No), int'(eno));
        chk({tag, ".full"},    int'(bus.O_Full),        int'(ef));
        chk({tag, ".empty"},   int'(bus.O_Empty),       int'(ee));
        chk({tag, ".pending"}, int'(bus.O_Num_Pending), int'(ep));
        chk({tag, ".err"},     int'(bus.O_Err),         int'(er));
    endtask

    task automatic drive(logic issue, logic [2:0] no, logic [3:0] mask, logic [3:0] lc, logic [11:0] lno);
        bus.I_Issue         = issue;
        bus.I_Issue_No      = no;
        bus.I_En_Lane       = mask;
        bus.I_Lane_Commit   = lc;
        bus.I_Lane_Issue_No = lno;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive(1'b0, 3'd0, 4'd0, 4'd0, 12'd0);

        // issue 2/F, all lanes commit, retire 2; then 1/0011 and 5/0001 with 5 completing first;
        // finally an empty-mask issue retiring by itself.
        vt[0]  = mk(1, 3'd2, 4'hF, 4'h0, 12'd0,                      0, 3'd0, 0, 0, 4'd1, 0);
        vt[1]  = mk(0, 3'd0, 4'h0, 4'hF, {3'd2, 3'd2, 3'd2, 3'd2},   0, 3'd0, 0, 0, 4'd1, 0);
        vt[2]  = mk(0, 3'd0, 4'h0, 4'h0, 12'd0,                      1, 3'd2, 0, 1, 4'd0, 0);
        vt[3]  = mk(0, 3'd0, 4'h0, 4'h0, 12'd0,                      0, 3'd0, 0, 1, 4'd0, 0);
        vt[4]  = mk(1, 3'd1, 4'h3, 4'h0, 12'd0,                      0, 3'd0, 0, 0, 4'd1, 0);
        vt[5]  = mk(1, 3'd5, 4'h1, 4'h0, 12'd0,                      0, 3'd0, 0, 0, 4'd2, 0);
        vt[6]  = mk(0, 3'd0, 4'h0, 4'h1, {9'd0, 3'd5},               0, 3'd0, 0, 0, 4'd2, 0);
        vt[7]  = mk(0, 3'd0, 4'h0, 4'h0, 12'd0,                      0, 3'd0, 0, 0, 4'd2, 0);
        vt[8]  = mk(0, 3'd0, 4'h0, 4'h3, {6'd0, 3'd1, 3'd1},         0, 3'd0, 0, 0, 4'd2, 0);
        vt[9]  = mk(0, 3'd0, 4'h0, 4'h0, 12'd0,                      1, 3'd1, 0, 0, 4'd1, 0);
        vt[10] = mk(0, 3'd0, 4'h0, 4'h0, 12'd0,                      1, 3'd5, 0, 1, 4'd0, 0);
        vt[11] = mk(0, 3'd0, 4'h0, 4'h0, 12'd0,                      0, 3'd0, 0, 1, 4'd0, 0);
        vt[12] = mk(1, 3'd3, 4'h0, 4'h0, 12'd0,                      0, 3'd0, 0, 0, 4'd1, 0);
        vt[13] = mk(0, 3'd0, 4'h0, 4'h0, 12'd0,                      1, 3'd3, 0, 1, 4'd0, 0);

        #3;
        chk("reset.commit_no", int'(bus.O_Commit_No), 0);
        check_outs("reset", 1'b0, 3'd0, 1'b0, 1'b1, 4'd0, 1'b0);
        #9;
        rst = 1'b0;
        step();

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].issue, vt[i].issue_no, vt[i].en_lane, vt[i].lc, vt[i].lno);
            step();
            check_outs($sformatf("vec%0d", i), vt[i].e_commit, vt[i].e_no, vt[i].e_full,
                       vt[i].e_empty, vt[i].e_pend, vt[i].e_err);
        end
        drive(1'b0, 3'd0, 4'd0, 4'd0, 12'd0);

        // Fill the table, then overflow it.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 4'hF, 4'h0, 12'd0);
            step();
        end
        drive(1'b0, 3'd0, 4'd0, 4'd0, 12'd0);
        check_outs("fill", 1'b0, 3'd0, 1'b1, 1'b0, 4'd8, 1'b0);
        drive(1'b1, 3'd0, 4'hF, 4'h0, 12'd0);
        step();
        drive(1'b0, 3'd0, 4'd0, 4'd0, 12'd0);
        check_outs("overflow", 1'b0, 3'd0, 1'b1, 1'b0, 4'd8, 1'b1);

        // Full table: head retires while its issue_no is reissued.
        pulse_reset();
        step();
        check_outs("rst2", 1'b0, 3'd0, 1'b0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 4'hF, 4'h0, 12'd0);
            step();
        end
        drive(1'b0, 3'd0, 4'h0, 4'hF, 12'd0);
        step();
        check_outs("coll.pre", 1'b0, 3'd0, 1'b1, 1'b0, 4'd8, 1'b0);
        drive(1'b1, 3'd0, 4'h3, 4'h1, 12'd0);
        step();
        check_outs("coll.retire", 1'b1, 3'd0, 1'b1, 1'b0, 4'd8, 1'b0);
        drive(1'b0, 3'd0, 4'h0, 4'h2, 12'd0);
        step();
        check_outs("coll.lane1", 1'b0, 3'd0, 1'b1, 1'b0, 4'd8, 1'b0);
        drive(1'b0, 3'd0, 4'h0, 4'h1, 12'd0);
        step();
        check_outs("coll.dup", 1'b0, 3'd0, 1'b1, 1'b0, 4'd8, 1'b1);

        // Commit from a lane outside the mask, then async reset while a retire pulse is high.
        pulse_reset();
        drive(1'b1, 3'd4, 4'h3, 4'h0, 12'd0);
        step();
        drive(1'b0, 3'd0, 4'h0, 4'h4, {3'd4, 3'd4, 3'd4, 3'd4});
        step();
        check_outs("badlane", 1'b0, 3'd0, 1'b0, 1'b0, 4'd1, 1'b1);
        drive(1'b0, 3'd0, 4'h0, 4'h0, 12'd0);
        step();
        check_outs("badlane.hold", 1'b0, 3'd0, 1'b0, 1'b0, 4'd1, 1'b1);
        drive(1'b0, 3'd0, 4'h0, 4'h3, {3'd4, 3'd4, 3'd4, 3'd4});
        step();
        check_outs("good.lanes", 1'b0, 3'd0, 1'b0, 1'b0, 4'd1, 1'b1);
        drive(1'b0, 3'd0, 4'h0, 4'h0, 12'd0);
        step();
        check_outs("good.retire", 1'b1, 3'd4, 1'b0, 1'b1, 4'd0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async.commit_no", int'(bus.O_Commit_No), 0);
        check_outs("async", 1'b0, 3'd0, 1'b0, 1'b1, 4'd0, 1'b0);
        #1;
        rst = 1'b0;
        step();
        check_outs("after", 1'b0, 3'd0, 1'b0, 1'b1, 4'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
